// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the pipelined ALU.
//   op_t    : 4-bit opcode encoding (9..15 are undefined and flagged Illegal)
//   state_t : sequencing FSM state (IDLE, MUL)
//   is_legal: true for every defined opcode, including MUL
package alu_pkg;

  localparam int              OP_W   = 4;
  localparam logic [OP_W-1:0] MUL_OP = 4'd8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_LSL = 4'd1,
    OP_LSR = 4'd2,
    OP_XOR = 4'd3,
    OP_SNE = 4'd4,
    OP_SEQ = 4'd5,
    OP_MSK = 4'd6,
    OP_ADC = 4'd7,
    OP_MUL = 4'd8
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic is_legal(op_t op);
    return (op <= OP_MUL);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational core for every single-cycle opcode (all but MUL).
// Ports:
//   a_i, b_i   : operands
//   op_i       : opcode
//   sc_i       : shift/carry input (already forced to 0 when cleared)
//   result_o   : operation result
//   sc_o       : new SC value, meaningful only when sc_we_o is set
//   sc_we_o    : the opcode writes SC
//   illegal_o  : the opcode is undefined (result is 0)
// MUL is handled by the iterative engine in alu_pipe; here it yields 0 and
// is not flagged illegal.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_t              op_i,
  input  logic             sc_i,
  output logic [WIDTH-1:0] result_o,
  output logic             sc_o,
  output logic             sc_we_o,
  output logic             illegal_o
);

  // One adder serves ADD and ADC; only ADC feeds SC in as carry.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, sc_i & (op_i == OP_ADC)};
  end

  always_comb begin
    result_o  = '0;
    sc_o      = sc_i;
    sc_we_o   = 1'b0;
    illegal_o = !is_legal(op_i);
    case (op_i)
      OP_ADD, OP_ADC: begin
        result_o = sum[WIDTH-1:0];
        sc_o     = sum[WIDTH];
        sc_we_o  = 1'b1;
      end
      OP_LSL: begin
        result_o = {a_i[WIDTH-2:0], sc_i};
        sc_o     = a_i[WIDTH-1];
        sc_we_o  = 1'b1;
      end
      OP_LSR: begin
        result_o = {sc_i, a_i[WIDTH-1:1]};
        sc_o     = a_i[0];
        sc_we_o  = 1'b1;
      end
      OP_XOR: result_o = a_i ^ b_i;
      OP_SNE: result_o = {{(WIDTH-1){1'b0}}, (a_i != b_i)};
      OP_SEQ: result_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      OP_MSK: result_o = a_i & (WIDTH'(1) << b_i[SHW-1:0]);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a persistent SC bit, registered flags and an
// iterative shift-and-add multiplier.
// Ports:
//   Clk, Reset         : clock (rising edge), async active-high reset
//   InValid / InReady  : operand handshake (InputA, InputB, OP, ScClr)
//   ScClr              : clear SC; an op accepted in the same cycle sees SC=0
//   OutValid / OutReady: result handshake (Out, Zero, Even, Illegal)
//   ScOut              : live value of the SC register
//   DbgState           : current FSM state, for observation only
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready. Out/flags hold while OutValid && !OutReady. InReady is high
// only in IDLE with the output slot free or draining this cycle, which
// allows one accept per cycle under continuous flow.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [OP_W-1:0]  OP,
  input  logic             ScClr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Even,
  output logic             ScOut,
  output logic             Illegal,
  output state_t           DbgState
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             even_q, even_d;
  logic             ill_q, ill_d;
  logic             valid_q, valid_d;
  logic             sc_q, sc_d;

  logic             in_ready;
  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic             sc_eff;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             load_ill;
  logic [WIDTH-1:0] acc_step;
  op_t              op_in;

  logic [WIDTH-1:0] comb_res;
  logic             comb_sc;
  logic             comb_sc_we;
  logic             comb_ill;

  assign op_in  = op_t'(OP);
  assign is_mul = (OP == MUL_OP);
  // ScClr takes effect before the op in the same cycle reads SC.
  assign sc_eff = sc_q & ~ScClr;

  alu_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_comb (
    .a_i       (InputA),
    .b_i       (InputB),
    .op_i      (op_in),
    .sc_i      (sc_eff),
    .result_o  (comb_res),
    .sc_o      (comb_sc),
    .sc_we_o   (comb_sc_we),
    .illegal_o (comb_ill)
  );

  // FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && is_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_last)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == ST_IDLE) && (!valid_q || OutReady);
    DbgState = state_q;
  end

  assign accept = InValid && in_ready;
  // cnt_q counts completed iterations; the WIDTH-th one finishes the product.
  assign mul_last = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH - 1));
  assign acc_step = mul_b_q[0] ? (acc_q + mul_a_q) : acc_q;

  // A result enters the output register either from a single-cycle accept or
  // from the last multiply iteration; the two never coincide since accept
  // requires IDLE.
  always_comb begin
    load     = mul_last || (accept && !is_mul);
    load_val = mul_last ? acc_step : comb_res;
    load_ill = mul_last ? 1'b0 : comb_ill;
  end

  always_comb begin
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (state_q == ST_MUL) begin
      acc_d   = acc_step;
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end else if (accept && is_mul) begin
      acc_d   = '0;
      mul_a_d = InputA;
      mul_b_d = InputB;
      cnt_d   = '0;
    end
  end

  always_comb begin
    out_d   = load ? load_val : out_q;
    zero_d  = load ? (load_val == '0) : zero_q;
    even_d  = load ? ~load_val[0] : even_q;
    ill_d   = load ? load_ill : ill_q;
    valid_d = load || (valid_q && !OutReady);
    sc_d    = (accept && !is_mul && comb_sc_we) ? comb_sc : sc_eff;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
      even_q  <= 1'b1;
      ill_q   <= 1'b0;
      valid_q <= 1'b0;
      sc_q    <= 1'b0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      even_q  <= even_d;
      ill_q   <= ill_d;
      valid_q <= valid_d;
      sc_q    <= sc_d;
    end
  end

  assign InReady  = in_ready;
  assign OutValid = valid_q;
  assign Out      = out_q;
  assign Zero     = zero_q;
  assign Even     = even_q;
  assign Illegal  = ill_q;
  assign ScOut    = sc_q;

endmodule
